// File: rtl/player_motion_fsm_if.sv
// -----------------------------------------------------------------------------
// player_motion_fsm_if
//
// Groups the player controller's per-frame inputs and its outputs into one
// bundle, so they travel together between the keyboard/collision side and the
// sprite/colour mapper side.
//
// Signals:
//   keycode        8  keyboard scan code for this frame
//   hit            1  one-frame damage pulse from the collision logic
//   PlayerX        10 sprite centre X
//   PlayerY        10 sprite centre Y
//   Player_Size_X  10 sprite box width
//   Player_Size_Y  10 sprite box height
//   Player_Status  4  0 idle, 1 walk, 2 rise, 3 fall, 4 attack, 5 respawn, 6 dead
//   Player_Life    4  remaining lives
//   Inverse        1  facing: 0 right, 1 left
//   invuln         1  damage immunity active
//
// Modports:
//   master  drives keycode/hit and observes the player state
//   slave   the player controller itself
// -----------------------------------------------------------------------------
interface player_motion_fsm_if;
  logic [7:0] keycode;
  logic       hit;
  logic [9:0] PlayerX;
  logic [9:0] PlayerY;
  logic [9:0] Player_Size_X;
  logic [9:0] Player_Size_Y;
  logic [3:0] Player_Status;
  logic [3:0] Player_Life;
  logic       Inverse;
  logic       invuln;

  modport master (
    output keycode,
    output hit,
    input  PlayerX,
    input  PlayerY,
    input  Player_Size_X,
    input  Player_Size_Y,
    input  Player_Status,
    input  Player_Life,
    input  Inverse,
    input  invuln
  );

  modport slave (
    input  keycode,
    input  hit,
    output PlayerX,
    output PlayerY,
    output Player_Size_X,
    output Player_Size_Y,
    output Player_Status,
    output Player_Life,
    output Inverse,
    output invuln
  );
endinterface

// File: rtl/player_motion_fsm.sv
// -----------------------------------------------------------------------------
// player_motion_fsm
//
// Per-frame player controller for the platformer. Every frame_clk edge it
// moves the player from the current keycode (walk, jump, fast-fall), applies
// gravity, resolves the platform surface, ceiling and pit, runs the attack
// timer, takes damage with invulnerability frames, and handles respawn and
// death. All player state leaves through registers.
//
// Ports:
//   frame_clk  frame-rate clock
//   Reset      asynchronous, active-high reset
//   pm         player_motion_fsm_if.slave bundle
//                in : keycode (50 left, 4F right, 51 down, 52 jump, 1B attack),
//                     hit (one-frame damage pulse)
//                out: PlayerX/PlayerY centre, Player_Size_X/Y box,
//                     Player_Status, Player_Life, Inverse, invuln
// -----------------------------------------------------------------------------
module player_motion_fsm #(
  parameter int X_CENTER      = 320,
  parameter int X_MIN         = 31,
  parameter int X_MAX         = 607,
  parameter int Y_MIN         = 100,
  parameter int PIT_Y         = 451,
  parameter int FLOOR         = 408,
  parameter int LEFT_EDGE     = 116,
  parameter int RIGHT_EDGE    = 523,
  parameter int SIZE_X        = 30,
  parameter int SIZE_Y        = 62,
  parameter int WALK_SPEED    = 2,
  parameter int JUMP_VEL      = 8,
  parameter int GRAVITY       = 1,
  parameter int MAX_FALL      = 8,
  parameter int LIVES         = 3,
  parameter int ATTACK_FRAMES = 12,
  parameter int INVULN_FRAMES = 60,
  parameter int DEAD_Y        = 215
) (
  input  logic               frame_clk,
  input  logic               Reset,
  player_motion_fsm_if.slave pm
);

  // Keyboard scan codes
  localparam logic [7:0] KEY_LEFT   = 8'h50;
  localparam logic [7:0] KEY_RIGHT  = 8'h4F;
  localparam logic [7:0] KEY_DOWN   = 8'h51;
  localparam logic [7:0] KEY_JUMP   = 8'h52;
  localparam logic [7:0] KEY_ATTACK = 8'h1B;

  // Player_Status encodings seen by the sprite mapper
  localparam logic [3:0] ST_IDLE    = 4'd0;
  localparam logic [3:0] ST_WALK    = 4'd1;
  localparam logic [3:0] ST_RISE    = 4'd2;
  localparam logic [3:0] ST_FALL    = 4'd3;
  localparam logic [3:0] ST_ATTACK  = 4'd4;
  localparam logic [3:0] ST_RESPAWN = 4'd5;
  localparam logic [3:0] ST_DEAD    = 4'd6;

  // Geometry is worked in 11-bit signed so that a step past zero or past the
  // screen edge is seen as out of range instead of wrapping.
  typedef logic signed [10:0] pos_t;
  typedef logic signed [5:0]  vel_t;

  localparam pos_t HALF_X  = pos_t'(SIZE_X / 2);
  localparam pos_t HALF_Y  = pos_t'(SIZE_Y / 2);
  localparam pos_t X_LO    = pos_t'(X_MIN + SIZE_X / 2);
  localparam pos_t X_HI    = pos_t'(X_MAX - SIZE_X / 2);
  localparam pos_t Y_TOP   = pos_t'(Y_MIN);
  localparam pos_t CEIL_Y  = pos_t'(Y_MIN + SIZE_Y / 2);
  localparam pos_t SPAWN_Y = pos_t'(FLOOR - SIZE_Y / 2);
  localparam pos_t FLOOR_Y = pos_t'(FLOOR);
  localparam pos_t PIT_LIM = pos_t'(PIT_Y);
  localparam pos_t PLAT_L  = pos_t'(LEFT_EDGE);
  localparam pos_t PLAT_R  = pos_t'(RIGHT_EDGE);
  localparam pos_t WALK    = pos_t'(WALK_SPEED);

  localparam vel_t VY_JUMP = vel_t'(-JUMP_VEL);
  localparam vel_t VY_MAX  = vel_t'(MAX_FALL);
  localparam vel_t VY_GRAV = vel_t'(GRAVITY);

  localparam int ATK_W = $clog2(ATTACK_FRAMES + 1);
  localparam int INV_W = $clog2(INVULN_FRAMES + 1);
  localparam logic [ATK_W-1:0] ATK_LOAD = ATK_W'(ATTACK_FRAMES);
  localparam logic [ATK_W-1:0] ATK_ONE  = ATK_W'(1);
  localparam logic [INV_W-1:0] INV_LOAD = INV_W'(INVULN_FRAMES);
  localparam logic [INV_W-1:0] INV_ONE  = INV_W'(1);

  localparam logic [9:0] X_SPAWN10 = 10'(X_CENTER);
  localparam logic [9:0] Y_SPAWN10 = 10'(FLOOR - SIZE_Y / 2);
  localparam logic [9:0] Y_DEAD10  = 10'(DEAD_Y);
  localparam logic [3:0] LIFE_INIT = 4'(LIVES);

  // Respawn and dead override the per-frame physics entirely.
  typedef enum logic [1:0] {
    MODE_ALIVE,
    MODE_RESPAWN,
    MODE_DEAD
  } mode_t;

  mode_t            mode_q;
  logic [9:0]       x_q;
  logic [9:0]       y_q;
  vel_t             vy_q;
  logic [3:0]       status_q;
  logic [3:0]       life_q;
  logic             inverse_q;
  logic             invuln_q;
  logic [ATK_W-1:0] atk_cnt_q;
  logic [INV_W-1:0] inv_cnt_q;

  pos_t             x_cur;
  pos_t             y_cur;
  pos_t             x_mv;
  pos_t             y_mv;
  vel_t             vy_mv;
  vel_t             vy_grav;
  vel_t             vy_n;
  logic             on_plat_cur;
  logic             grounded_cur;
  logic             airborne_cur;
  logic             on_plat_new;
  logic             grounded_new;
  logic             jump;
  logic             inverse_n;
  logic             pit;
  logic             take_hit;
  logic             last_life;
  logic [3:0]       motion_status;
  logic [3:0]       status_n;
  logic [3:0]       life_dec;
  logic [ATK_W-1:0] atk_n;
  logic [INV_W-1:0] inv_dec;
  logic [INV_W-1:0] inv_next;

  // Where the player stands right now: on the platform's horizontal span,
  // and resting on its top surface. Any nonzero vy also counts as airborne,
  // which is what lets the frame after a jump start moving upward.
  always_comb begin
    x_cur        = pos_t'({1'b0, x_q});
    y_cur        = pos_t'({1'b0, y_q});
    on_plat_cur  = ((x_cur + HALF_X) >= PLAT_L) && ((x_cur - HALF_X) <= PLAT_R);
    grounded_cur = ((y_cur + HALF_Y) == FLOOR_Y) && on_plat_cur;
    airborne_cur = !grounded_cur || (vy_q != '0);
  end

  // Horizontal step and facing. Walking works in the air too; the result is
  // clamped to the screen so the sprite never wraps around.
  always_comb begin
    x_mv      = x_cur;
    inverse_n = inverse_q;
    if (pm.keycode == KEY_LEFT) begin
      x_mv      = x_cur - WALK;
      inverse_n = 1'b1;
    end else if (pm.keycode == KEY_RIGHT) begin
      x_mv      = x_cur + WALK;
      inverse_n = 1'b0;
    end
    if (x_mv < X_LO) begin
      x_mv = X_LO;
    end else if (x_mv > X_HI) begin
      x_mv = X_HI;
    end
    on_plat_new = ((x_mv + HALF_X) >= PLAT_L) && ((x_mv - HALF_X) <= PLAT_R);
  end

  // Vertical step. A jump only loads vy; the player first leaves the ground
  // on the following frame. Landing uses the new X so that drifting back over
  // the platform while falling still catches the surface. Walking off the
  // edge needs no special case: vy stays 0 and the next frame sees the
  // player as not grounded, so gravity starts then.
  always_comb begin
    jump  = (pm.keycode == KEY_JUMP) && grounded_cur;
    vy_mv = vy_q;
    if (jump) begin
      vy_mv = VY_JUMP;
    end else if ((pm.keycode == KEY_DOWN) && airborne_cur) begin
      vy_mv = VY_MAX;
    end
    y_mv    = y_cur;
    vy_n    = vy_mv;
    vy_grav = vy_mv + VY_GRAV;
    if (!jump && airborne_cur) begin
      y_mv = y_cur + pos_t'({{5{vy_mv[5]}}, vy_mv});
      vy_n = (vy_grav > VY_MAX) ? VY_MAX : vy_grav;
      if ((vy_n > 6'sd0) && on_plat_new && ((y_mv + HALF_Y) >= FLOOR_Y)) begin
        y_mv = SPAWN_Y;
        vy_n = '0;
      end
    end
    if ((y_mv - HALF_Y) < Y_TOP) begin
      y_mv = CEIL_Y;
      vy_n = '0;
    end
    grounded_new = ((y_mv + HALF_Y) == FLOOR_Y) && on_plat_new;
    pit          = (y_mv + HALF_Y) >= PIT_LIM;
  end

  // Status, attack timer and damage bookkeeping for a normal frame. The
  // attack timer only loads from zero, so holding or re-pressing the attack
  // key cannot stretch an attack. A pit takes priority over a hit so the two
  // landing together cost only one life.
  always_comb begin
    if (vy_n < 6'sd0) begin
      motion_status = ST_RISE;
    end else if (!grounded_new || (vy_n != '0)) begin
      motion_status = ST_FALL;
    end else if ((pm.keycode == KEY_LEFT) || (pm.keycode == KEY_RIGHT)) begin
      motion_status = ST_WALK;
    end else begin
      motion_status = ST_IDLE;
    end

    atk_n = '0;
    if ((pm.keycode == KEY_ATTACK) && (atk_cnt_q == '0)) begin
      atk_n = ATK_LOAD;
    end else if (atk_cnt_q != '0) begin
      atk_n = atk_cnt_q - ATK_ONE;
    end
    status_n = (atk_n != '0) ? ST_ATTACK : motion_status;

    take_hit  = pm.hit && (inv_cnt_q == '0);
    last_life = (life_q == 4'd1);
    life_dec  = life_q - 4'd1;

    inv_dec  = (inv_cnt_q != '0) ? (inv_cnt_q - INV_ONE) : '0;
    inv_next = inv_dec;
    if ((mode_q == MODE_ALIVE) && ((pit && !last_life) || (!pit && take_hit))) begin
      inv_next = INV_LOAD;
    end
  end

  // Main state register. Alive frames commit the physics computed above,
  // unless the player fell into the pit or took a fatal hit. Respawn loads
  // the spawn pose at once and shows status 5 for one frame; dead parks the
  // sprite and ignores everything until Reset.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      mode_q    <= MODE_ALIVE;
      x_q       <= X_SPAWN10;
      y_q       <= Y_SPAWN10;
      vy_q      <= '0;
      status_q  <= ST_IDLE;
      life_q    <= LIFE_INIT;
      inverse_q <= 1'b0;
      invuln_q  <= 1'b0;
      atk_cnt_q <= '0;
      inv_cnt_q <= '0;
    end else begin
      inv_cnt_q <= inv_next;
      invuln_q  <= (inv_next != '0);
      case (mode_q)
        MODE_ALIVE: begin
          if (pit || (take_hit && last_life)) begin
            life_q    <= life_dec;
            x_q       <= X_SPAWN10;
            vy_q      <= '0;
            atk_cnt_q <= '0;
            if (last_life) begin
              mode_q   <= MODE_DEAD;
              y_q      <= Y_DEAD10;
              status_q <= ST_DEAD;
            end else begin
              mode_q   <= MODE_RESPAWN;
              y_q      <= Y_SPAWN10;
              status_q <= ST_RESPAWN;
            end
          end else begin
            x_q       <= x_mv[9:0];
            y_q       <= y_mv[9:0];
            vy_q      <= vy_n;
            inverse_q <= inverse_n;
            status_q  <= status_n;
            atk_cnt_q <= atk_n;
            if (take_hit) begin
              life_q <= life_dec;
            end
          end
        end
        MODE_RESPAWN: begin
          mode_q   <= MODE_ALIVE;
          status_q <= ST_IDLE;
        end
        MODE_DEAD: begin
          mode_q <= MODE_DEAD;
        end
        default: begin
          mode_q <= MODE_DEAD;
        end
      endcase
    end
  end

  assign pm.PlayerX       = x_q;
  assign pm.PlayerY       = y_q;
  assign pm.Player_Size_X = 10'(SIZE_X);
  assign pm.Player_Size_Y = 10'(SIZE_Y);
  assign pm.Player_Status = status_q;
  assign pm.Player_Life   = life_q;
  assign pm.Inverse       = inverse_q;
  assign pm.invuln        = invuln_q;

endmodule

// File: tb/tb_player_motion_fsm.sv
// -----------------------------------------------------------------------------
// tb_player_motion_fsm
//
// Directed bench for player_motion_fsm: walking, jump arc, fast-fall, attack
// timing, damage with immunity, pit respawn, death and asynchronous reset.
// Expected values are worked out by hand from the movement rules.
// -----------------------------------------------------------------------------
module tb_player_motion_fsm;

  logic frame_clk = 1'b0;
  logic Reset;
  int   checks = 0;
  int   passes = 0;

  player_motion_fsm_if bus ();

  player_motion_fsm dut (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .pm        (bus)
  );

  always #5 frame_clk = ~frame_clk;

  // Hold the given key for a number of frames and sample 1 ns after each
  // rising edge; hit is a single-frame pulse so it drops after the call.
  task automatic applyStimulus(input logic [7:0] key, input logic hitIn, input int frames);
    for (int i = 0; i < frames; i++) begin
      bus.keycode = key;
      bus.hit     = hitIn;
      @(posedge frame_clk);
      #1;
    end
    bus.hit = 1'b0;
  endtask

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed == expected) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  initial begin
    int jumpY[17];
    int fallY[4];
    jumpY = '{369, 362, 356, 351, 347, 344, 342, 341, 341,
              342, 344, 347, 351, 356, 362, 369, 377};
    fallY = '{357, 365, 373, 377};

    Reset       = 1'b1;
    bus.keycode = 8'h00;
    bus.hit     = 1'b0;
    #12;
    checkOutput("rst_x",      bus.PlayerX, 320);
    checkOutput("rst_y",      bus.PlayerY, 377);
    checkOutput("rst_status", bus.Player_Status, 0);
    checkOutput("rst_life",   bus.Player_Life, 3);
    checkOutput("rst_inv",    bus.Inverse, 0);
    checkOutput("rst_invuln", bus.invuln, 0);
    checkOutput("size_x",     bus.Player_Size_X, 30);
    checkOutput("size_y",     bus.Player_Size_Y, 62);
    Reset = 1'b0;

    // Walk right for ten frames, stop, then one step left
    applyStimulus(8'h4F, 1'b0, 10);
    checkOutput("walk_x",      bus.PlayerX, 340);
    checkOutput("walk_y",      bus.PlayerY, 377);
    checkOutput("walk_status", bus.Player_Status, 1);
    checkOutput("walk_inv",    bus.Inverse, 0);
    applyStimulus(8'h00, 1'b0, 1);
    checkOutput("stop_status", bus.Player_Status, 0);
    checkOutput("stop_x",      bus.PlayerX, 340);
    applyStimulus(8'h50, 1'b0, 1);
    checkOutput("left_x",      bus.PlayerX, 338);
    checkOutput("left_inv",    bus.Inverse, 1);
    checkOutput("left_status", bus.Player_Status, 1);
    applyStimulus(8'h00, 1'b0, 1);

    // Full jump arc; a second jump press on frame 3 must change nothing
    applyStimulus(8'h52, 1'b0, 1);
    checkOutput("jump0_y",      bus.PlayerY, 377);
    checkOutput("jump0_status", bus.Player_Status, 2);
    for (int f = 0; f < 17; f++) begin
      applyStimulus((f == 2) ? 8'h52 : 8'h00, 1'b0, 1);
      checkOutput($sformatf("jump_y_f%0d", f + 1), bus.PlayerY, jumpY[f]);
      checkOutput($sformatf("jump_st_f%0d", f + 1), bus.Player_Status,
                  (f < 7) ? 2 : ((f < 16) ? 3 : 0));
    end

    // Fast-fall from the apex lands exactly on the surface
    applyStimulus(8'h52, 1'b0, 1);
    applyStimulus(8'h00, 1'b0, 8);
    checkOutput("ff_apex_y", bus.PlayerY, 341);
    applyStimulus(8'h51, 1'b0, 1);
    checkOutput("ff_y1",      bus.PlayerY, 349);
    checkOutput("ff_status1", bus.Player_Status, 3);
    for (int f = 0; f < 4; f++) begin
      applyStimulus(8'h00, 1'b0, 1);
      checkOutput($sformatf("ff_y%0d", f + 2), bus.PlayerY, fallY[f]);
    end
    checkOutput("ff_land_status", bus.Player_Status, 0);

    // Attack while walking; a repeat press mid-attack must not extend it
    applyStimulus(8'h4F, 1'b0, 2);
    checkOutput("atk_pre_x", bus.PlayerX, 342);
    applyStimulus(8'h1B, 1'b0, 1);
    checkOutput("atk_start_status", bus.Player_Status, 4);
    checkOutput("atk_start_x",      bus.PlayerX, 342);
    applyStimulus(8'h4F, 1'b0, 4);
    checkOutput("atk_walk_x",      bus.PlayerX, 350);
    checkOutput("atk_walk_status", bus.Player_Status, 4);
    applyStimulus(8'h1B, 1'b0, 1);
    checkOutput("atk_repeat_status", bus.Player_Status, 4);
    applyStimulus(8'h4F, 1'b0, 6);
    checkOutput("atk_last_status", bus.Player_Status, 4);
    checkOutput("atk_last_x",      bus.PlayerX, 362);
    applyStimulus(8'h4F, 1'b0, 1);
    checkOutput("atk_end_status", bus.Player_Status, 1);
    checkOutput("atk_end_x",      bus.PlayerX, 364);

    // Damage: hit, ignored hit under immunity, immunity expiry, hit again
    applyStimulus(8'h00, 1'b1, 1);
    checkOutput("hit1_life",   bus.Player_Life, 2);
    checkOutput("hit1_invuln", bus.invuln, 1);
    checkOutput("hit1_status", bus.Player_Status, 0);
    applyStimulus(8'h00, 1'b0, 29);
    applyStimulus(8'h00, 1'b1, 1);
    checkOutput("hit2_life",   bus.Player_Life, 2);
    applyStimulus(8'h00, 1'b0, 29);
    checkOutput("invuln_k59", bus.invuln, 1);
    applyStimulus(8'h00, 1'b0, 1);
    checkOutput("invuln_k60", bus.invuln, 0);
    applyStimulus(8'h00, 1'b1, 1);
    checkOutput("hit3_life",   bus.Player_Life, 1);
    checkOutput("hit3_invuln", bus.invuln, 1);

    // Asynchronous reset in the middle of an attack
    applyStimulus(8'h1B, 1'b0, 1);
    checkOutput("ra_status", bus.Player_Status, 4);
    applyStimulus(8'h50, 1'b0, 2);
    checkOutput("ra_x",   bus.PlayerX, 360);
    checkOutput("ra_inv", bus.Inverse, 1);
    #2;
    Reset = 1'b1;
    #1;
    checkOutput("ra_rst_x",      bus.PlayerX, 320);
    checkOutput("ra_rst_y",      bus.PlayerY, 377);
    checkOutput("ra_rst_status", bus.Player_Status, 0);
    checkOutput("ra_rst_life",   bus.Player_Life, 3);
    checkOutput("ra_rst_inv",    bus.Inverse, 0);
    checkOutput("ra_rst_invuln", bus.invuln, 0);
    @(posedge frame_clk);
    #1;
    checkOutput("ra_hold_x", bus.PlayerX, 320);
    #2;
    Reset = 1'b0;

    // Walk off the left edge into the pit, respawn with immunity
    applyStimulus(8'h50, 1'b0, 119);
    checkOutput("pit_pre_x",      bus.PlayerX, 82);
    checkOutput("pit_pre_y",      bus.PlayerY, 413);
    checkOutput("pit_pre_status", bus.Player_Status, 3);
    checkOutput("pit_pre_life",   bus.Player_Life, 3);
    applyStimulus(8'h50, 1'b0, 1);
    checkOutput("pit_status", bus.Player_Status, 5);
    checkOutput("pit_life",   bus.Player_Life, 2);
    checkOutput("pit_invuln", bus.invuln, 1);
    applyStimulus(8'h00, 1'b0, 1);
    checkOutput("resp_status", bus.Player_Status, 0);
    checkOutput("resp_x",      bus.PlayerX, 320);
    checkOutput("resp_y",      bus.PlayerY, 377);
    checkOutput("resp_invuln", bus.invuln, 1);
    applyStimulus(8'h00, 1'b0, 58);
    checkOutput("resp_invuln_59", bus.invuln, 1);
    applyStimulus(8'h00, 1'b0, 1);
    checkOutput("resp_invuln_60", bus.invuln, 0);

    // Last life lost to hits, then dead ignores keys and hits
    applyStimulus(8'h00, 1'b1, 1);
    checkOutput("d_hit1_life", bus.Player_Life, 1);
    applyStimulus(8'h00, 1'b0, 60);
    checkOutput("d_invuln_off", bus.invuln, 0);
    applyStimulus(8'h00, 1'b1, 1);
    checkOutput("dead_life",   bus.Player_Life, 0);
    checkOutput("dead_status", bus.Player_Status, 6);
    checkOutput("dead_x",      bus.PlayerX, 320);
    checkOutput("dead_y",      bus.PlayerY, 215);
    applyStimulus(8'h4F, 1'b0, 3);
    checkOutput("dead_keys_x",      bus.PlayerX, 320);
    checkOutput("dead_keys_y",      bus.PlayerY, 215);
    checkOutput("dead_keys_status", bus.Player_Status, 6);
    applyStimulus(8'h52, 1'b1, 1);
    checkOutput("dead_jump_y",    bus.PlayerY, 215);
    checkOutput("dead_hit_life",  bus.Player_Life, 0);
    #2;
    Reset = 1'b1;
    #1;
    checkOutput("dead_rst_life",   bus.Player_Life, 3);
    checkOutput("dead_rst_status", bus.Player_Status, 0);
    checkOutput("dead_rst_y",      bus.PlayerY, 377);
    #3;
    Reset = 1'b0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
